// File: rtl/mlp_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed MLP classifier.
// Saturation helpers are only referenced when MLP_SATURATE_EN is defined.
package mlp_pkg;

    typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_e;

    typedef enum logic [1:0] {MAC_PASS, MAC_BIAS, MAC_ADD, MAC_MUL} mac_mode_e;

    // Clamp a wide signed value into a w-bit signed range.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        return sat_trunc(a + b, w);
    endfunction

    function automatic int hid_base(input int j, input int n_in);
        return j * (n_in + 1);
    endfunction

    function automatic int out_base(input int k, input int n_in, input int n_hid);
        return n_hid * (n_in + 1) + k * (n_hid + 1);
    endfunction

endpackage

// File: rtl/mlp_mac_unit.sv
// Single shared accumulate step: bias load, weight add, or product add.
// MLP_SATURATE_EN selects clamping arithmetic; otherwise products truncate and sums wrap.
module mlp_mac_unit
    import mlp_pkg::*;
#(
    parameter int W_W   = 8,
    parameter int ACC_W = 16
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic signed [ACC_W-1:0] term_i,
    input  logic signed [W_W-1:0]   weight_i,
    input  mac_mode_e               mode_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] acc_sum;

    assign w_ext = ACC_W'(weight_i);

`ifdef MLP_SATURATE_EN
    localparam int PW = ACC_W + W_W;
    logic signed [PW-1:0] prod_full;

    assign prod_full = PW'(term_i) * PW'(weight_i);
    assign prod      = ACC_W'(sat_trunc(64'(prod_full), ACC_W));
`else
    assign prod = term_i * w_ext;
`endif

    always_comb begin
        addend = '0;
        case (mode_i)
            MAC_ADD: addend = w_ext;
            MAC_MUL: addend = prod;
            default: addend = '0;
        endcase
    end

`ifdef MLP_SATURATE_EN
    assign acc_sum = ACC_W'(sat_add(64'(acc_i), 64'(addend), ACC_W));
`else
    assign acc_sum = acc_i + addend;
`endif

    always_comb begin
        acc_o = acc_sum;
        if (mode_i == MAC_BIAS) acc_o = w_ext;
    end

endmodule

// File: rtl/mlp_seq_classifier.sv
// Two-layer MLP classifier (binary features -> ReLU hidden -> argmax) stepped one term per cycle.
// Arithmetic mode is chosen in mlp_mac_unit by MLP_SATURATE_EN.
module mlp_seq_classifier
    import mlp_pkg::*;
#(
    parameter  int N_IN  = 7,
    parameter  int N_HID = 3,
    parameter  int N_OUT = 10,
    parameter  int W_W   = 8,
    parameter  int ACC_W = 16,
    localparam int NW    = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1),
    localparam int AW    = $clog2(NW),
    localparam int CLS_W = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN-1:0]         in_bits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CLS_W-1:0]        out_class,
    output logic signed [ACC_W-1:0] out_score,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic signed [W_W-1:0]   cfg_wdata,
    output logic                    busy
);

    localparam int TMAX = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IMAX = (N_HID > N_OUT) ? N_HID : N_OUT;
    localparam int IW   = (IMAX > 1) ? $clog2(IMAX) : 1;

    state_e                  state_q;
    logic [N_IN-1:0]         bits_q;
    logic signed [W_W-1:0]   wmem_q [NW];
    logic signed [ACC_W-1:0] hid_q [N_HID];
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] max_q;
    logic [CLS_W-1:0]        max_cls_q;
    logic [TW-1:0]           term_q;
    logic [IW-1:0]           idx_q;
    logic                    in_ready_q;
    logic                    busy_q;
    logic                    out_valid_q;
    logic [CLS_W-1:0]        out_class_q;
    logic signed [ACC_W-1:0] out_score_q;

    int                      rd_addr;
    logic signed [W_W-1:0]   w_rd;
    logic signed [ACC_W-1:0] term_op;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] hid_new;
    logic                    bit_sel;
    logic                    last_term;
    logic                    last_idx;
    mac_mode_e               mode;

    // term 0 of every neuron/class is its bias; term t>0 refers to input/hidden t-1
    always_comb begin
        rd_addr   = 0;
        mode      = MAC_PASS;
        term_op   = '0;
        bit_sel   = 1'b0;
        last_term = 1'b0;
        last_idx  = 1'b0;
        w_rd      = '0;
        for (int i = 0; i < N_IN; i++)
            if (int'(term_q) == i + 1) bit_sel = bits_q[i];
        for (int j = 0; j < N_HID; j++)
            if (int'(term_q) == j + 1) term_op = hid_q[j];
        case (state_q)
            HID: begin
                rd_addr   = hid_base(int'(idx_q), N_IN) + int'(term_q);
                mode      = (term_q == '0) ? MAC_BIAS : (bit_sel ? MAC_ADD : MAC_PASS);
                last_term = (int'(term_q) == N_IN);
                last_idx  = (int'(idx_q) == N_HID - 1);
            end
            OUT: begin
                rd_addr   = out_base(int'(idx_q), N_IN, N_HID) + int'(term_q);
                mode      = (term_q == '0) ? MAC_BIAS : MAC_MUL;
                last_term = (int'(term_q) == N_HID);
                last_idx  = (int'(idx_q) == N_OUT - 1);
            end
            default: ;
        endcase
        for (int a = 0; a < NW; a++)
            if (a == rd_addr) w_rd = wmem_q[a];
    end

    mlp_mac_unit #(
        .W_W   (W_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .acc_i    (acc_q),
        .term_i   (term_op),
        .weight_i (w_rd),
        .mode_i   (mode),
        .acc_o    (acc_d)
    );

    assign hid_new = acc_d[ACC_W-1] ? '0 : acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bits_q      <= '0;
            acc_q       <= '0;
            max_q       <= '0;
            max_cls_q   <= '0;
            term_q      <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_score_q <= '0;
            for (int a = 0; a < NW; a++) wmem_q[a] <= '0;
            for (int j = 0; j < N_HID; j++) hid_q[j] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    for (int a = 0; a < NW; a++)
                        if (cfg_we && int'(cfg_addr) == a) wmem_q[a] <= cfg_wdata;
                    if (in_valid) begin
                        bits_q     <= in_bits;
                        term_q     <= '0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= HID;
                    end
                end
                HID: begin
                    acc_q <= acc_d;
                    if (last_term) begin
                        for (int j = 0; j < N_HID; j++)
                            if (int'(idx_q) == j) hid_q[j] <= hid_new;
                        term_q <= '0;
                        if (last_idx) begin
                            idx_q   <= '0;
                            state_q <= OUT;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        term_q <= term_q + TW'(1);
                    end
                end
                OUT: begin
                    acc_q <= acc_d;
                    if (last_term) begin
                        // strict compare keeps the lowest index on ties
                        if (idx_q == '0 || acc_d > max_q) begin
                            max_q     <= acc_d;
                            max_cls_q <= CLS_W'(idx_q);
                        end
                        term_q <= '0;
                        if (last_idx) begin
                            idx_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        term_q <= term_q + TW'(1);
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_class_q <= max_cls_q;
                        out_score_q <= max_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;

endmodule

// File: tb/tb_mlp_seq_classifier.sv
// Randomised bench for mlp_seq_classifier against an arithmetic reference model.
// Expected arithmetic follows MLP_SATURATE_EN when defined for the build.
module tb_mlp_seq_classifier;

    localparam int N_IN  = 7;
    localparam int N_HID = 3;
    localparam int N_OUT = 10;
    localparam int NW    = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1);
    localparam int OB    = N_HID * (N_IN + 1);
    localparam int LAT   = N_HID * (N_IN + 1) + N_OUT * (N_HID + 1) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [6:0]        in_bits = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [3:0]        out_class;
    logic signed [15:0] out_score;
    logic              cfg_we = 1'b0;
    logic [5:0]        cfg_addr = '0;
    logic signed [7:0] cfg_wdata = '0;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int wm [NW];

    mlp_seq_classifier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint clip(input longint v);
`ifdef MLP_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        longint m;
        m = v & 64'hFFFF;
        if (m >= 32768) m = m - 65536;
        return m;
`endif
    endfunction

    task automatic model(input logic [6:0] b, output int cls, output longint sc);
        longint h [N_HID];
        longint s;
        for (int j = 0; j < N_HID; j++) begin
            s = wm[j * (N_IN + 1)];
            for (int i = 0; i < N_IN; i++)
                if (b[i]) s = clip(s + wm[j * (N_IN + 1) + 1 + i]);
            h[j] = (s < 0) ? 0 : s;
        end
        cls = 0;
        sc  = 0;
        for (int k = 0; k < N_OUT; k++) begin
            s = wm[OB + k * (N_HID + 1)];
            for (int j = 0; j < N_HID; j++)
                s = clip(s + clip(h[j] * wm[OB + k * (N_HID + 1) + 1 + j]));
            if (k == 0 || s > sc) begin
                cls = k;
                sc  = s;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_class", out_class, 0);
        check("rst_out_score", out_score, 0);
        rst = 1'b0;
        for (int a = 0; a < NW; a++) wm[a] = 0;
    endtask

    task automatic load_w(input int a, input int v);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 6'(a); cfg_wdata = 8'(v);
        wm[a] = v;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_random();
        for (int a = 0; a < NW; a++) begin
            @(negedge clk);
            cfg_we = 1'b1; cfg_addr = 6'(a);
            wm[a] = int'($urandom_range(0, 255)) - 128;
            cfg_wdata = 8'(wm[a]);
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_vec(input logic [6:0] b, input bit wr, input int wa, input int wv,
                           input bit poke, input int hold,
                           output int got_cls, output longint got_sc);
        int     cyc;
        int     mcls;
        longint msc;
        @(negedge clk);
        in_bits = b; in_valid = 1'b1;
        if (wr) begin
            cfg_we = 1'b1; cfg_addr = 6'(wa); cfg_wdata = 8'(wv);
            wm[wa] = wv;
        end
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_in_ready", in_ready, 0);
        model(b, mcls, msc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            cfg_we = 1'b0; in_valid = 1'b0;
            if (poke && cyc == 5) begin
                cfg_we = 1'b1; cfg_addr = 6'd40; cfg_wdata = -8'sd100;
                in_valid = 1'b1; in_bits = ~b;
            end
        end
        cfg_we = 1'b0; in_valid = 1'b0;
        check("latency", cyc, LAT);
        check("class", out_class, mcls);
        check("score", out_score, msc);
        got_cls = int'(out_class);
        got_sc  = longint'(out_score);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_class", out_class, mcls);
            check("hold_score", out_score, msc);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
        check("drain_busy", busy, 0);
    endtask

    initial begin
        int     c;
        longint s;
        logic [6:0] rb;

        do_reset();

        // T1
        load_w(OB + 4 * 4, 38);
        load_w(OB + 9 * 4, 35);
        run_vec(7'h55, 0, 0, 0, 0, 0, c, s);
        check("t1_class", c, 4);
        check("t1_score", s, 38);
        do_reset();

        // T2
        load_w(OB + 2 * 4, 5);
        load_w(OB + 7 * 4, 5);
        run_vec(7'($urandom), 0, 0, 0, 0, 0, c, s);
        check("t2_class", c, 2);
        check("t2_score", s, 5);
        do_reset();

        // T3
        load_w(0, -3);
        load_w(1, 5);
        load_w(OB + 5 * 4 + 1, 10);
        load_w(OB, 1);
        run_vec(7'h00, 0, 0, 0, 0, 0, c, s);
        check("t3a_class", c, 0);
        check("t3a_score", s, 1);
        run_vec(7'h01, 0, 0, 0, 0, 0, c, s);
        check("t3b_class", c, 5);
        check("t3b_score", s, 20);
        do_reset();

        // T4
        for (int a = 0; a <= N_IN; a++) load_w(a, 127);
        load_w(OB + 3 * 4 + 1, 127);
        run_vec(7'h7F, 0, 0, 0, 0, 0, c, s);
`ifdef MLP_SATURATE_EN
        check("t4_class", c, 3);
        check("t4_score", s, 32767);
`else
        check("t4_class", c, 0);
        check("t4_score", s, 0);
`endif
        do_reset();

        // T5: backpressure plus ignored cfg/in_valid while busy
        load_random();
        rb = 7'($urandom);
        run_vec(rb, 0, 0, 0, 1, 10, c, s);
        run_vec(rb, 0, 0, 0, 0, 0, c, s);

        // write accepted in the same cycle as the vector
        run_vec(7'($urandom), 1, OB + 9 * 4, 127, 0, 0, c, s);

        for (int n = 0; n < 6; n++) begin
            load_random();
            run_vec(7'($urandom), 1, int'($urandom_range(0, NW - 1)),
                    int'($urandom_range(0, 255)) - 128, n[0], n, c, s);
        end

        // T6: reset mid-HID
        @(negedge clk);
        in_bits = 7'($urandom); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_out_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_in_ready", in_ready, 1);
        for (int a = 0; a < NW; a++) wm[a] = 0;
        run_vec(7'($urandom), 0, 0, 0, 0, 0, c, s);
        check("t6_class", c, 0);
        check("t6_score", s, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
